move_commit_sequencer: RTL
==========================

// Module: move_commit_sequencer
// PURPOSE
//  Sequences the board updater. Accepts move and undo requests from the engine/UI through a valid/ready handshake.
//  Keeps a LIFO move history so that undo replays the exact move record, and tracks the side to move.
//  Drives the updater's move fields and holds them stable for SETTLE cycles, then reports completion.
//  Sits between the move generator/search and board_updater. It is the only master of the updater's inputs.
// PARAMETERS
//  DEPTH   64  history entries (power of 2, >=2); max plies undoable
//  SETTLE  2   cycles the updater inputs are held with upd_en=1 (>=1)
// PORTS
//  clk             in   1   system clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  new_game        in   1   level/pulse: start the init sequence (wins over req_valid)
//  req_valid       in   1   request present
//  req_ready       out  1   request accepted when req_valid&req_ready
//  req_undo        in   1   1=undo the last move, 0=apply the move fields below
//  req_from        in   6   source square index 0..63
//  req_to          in   6   destination square index 0..63
//  req_moving      in   6   one-hot piece: 000001 P,000010 R,000100 N,001000 B,010000 Q,100000 K
//  req_captured    in   6   one-hot captured piece, 000000=none
//  req_castling    in   2   00 none, 01 queen side, 10 king side
//  req_enpassant   in   5   00001 none, 00010 UL, 00100 UR, 01000 DL, 10000 DR
//  done            out  1   1-cycle pulse: request (or init) fully applied
//  err             out  1   1-cycle pulse: request rejected (push when full / undo when empty)
//  hist_count      out  $clog2(DEPTH)+1  entries held
//  color_type      out  1   side to move: 1 white, 0 black
//  upd_en          out  1   updater enable; high during the APPLY/INIT hold window only
//  upd_init        out  1   updater init strobe
//  upd_undo        out  1   updater undo flag
//  upd_initialPosition out 64 one-hot of from square
//  upd_movedPosition   out 64 one-hot of to square
//  upd_movingPiece/upd_capturedPiece out 6; upd_castling out 2; upd_enpassant out 5
// BEHAVIOUR
//  Reset: state IDLE. req_ready=1, done=0, err=0, hist_count=0, color_type=1.
//   All upd_* = 0, except upd_enpassant=5'b00001.
//  Record is 31 bits: {from,to,moving,captured,castling,enpassant}. Stored in a DEPTH x 31 LIFO with stack pointer sp.
//  States: IDLE, INIT, APPLY, DONE. req_ready=1 only in IDLE with new_game=0.
//  IDLE + new_game: -> INIT.
//   Hold upd_init=1 and upd_en=1 for SETTLE cycles. Set sp=0 and color_type=1. Then -> DONE.
//  IDLE + accept, req_undo=0:
//   - If full: err pulse next cycle; stay IDLE; no updater activity.
//   - Else: push the record, sp+1, drive the record with upd_undo=0. -> APPLY.
//  IDLE + accept, req_undo=1:
//   - If empty: err pulse next cycle; stay IDLE.
//   - Else: sp-1, drive the record at sp-1 with upd_undo=1. -> APPLY.
//     Initial/moved positions are NOT swapped; the updater handles reversal.
//  APPLY: upd_en=1 for exactly SETTLE cycles, with all fields stable across the window. Then -> DONE.
//  DONE: done=1 for one cycle. Toggle color_type on apply or undo (not on init). upd_en=0. -> IDLE.
//   upd_* fields keep their last values; nothing is meaningful while upd_en=0.
//  Latency: accept edge -> done pulse = SETTLE+1 cycles. Back-to-back throughput is one request per SETTLE+2 cycles.
//  One-hot outputs: upd_*Position = 64'd1 << index. Exactly one bit is set during APPLY.
//  new_game during APPLY/DONE: ignored until IDLE. It is level-sampled, so it is held by the requester.
//  Reset mid-APPLY: everything returns to reset values asynchronously. The history is lost.
//  Inputs are not validated (e.g. illegal one-hot values pass through). Legality is the move generator's job.
// STRUCTURE
//  Shared package/header: piece one-hot codes, castling and en-passant codes, WHITE/BLACK, record field offsets, RECW=31.
//  Sub-module: move_history_lifo (push/pop/top, full/empty, count). No reset is needed on its storage array.
//  Controller FSM plus index-to-one-hot decode stay in this file.
// TESTING
//  1. Reset, then new_game for 1 cycle -> upd_init=1 and upd_en=1 for 2 cycles, done on cycle 3, color_type=1, hist_count=0.
//  2. Apply from=3, to=1, K, castling=10 -> upd_initialPosition=64'h8, upd_movedPosition=64'h2, upd_movingPiece=100000;
//     done after 3 cycles; color_type=0; hist_count=1.
//  3. Push 2 moves, then undo twice -> records return in reverse order with upd_undo=1; hist_count 2->1->0; color_type back to 1.
//  4. Undo with hist_count=0 -> err pulse; upd_en stays 0; color_type unchanged.
//  5. Fill to DEPTH, then one more apply -> err pulse; hist_count stays DEPTH; top entry unchanged (verified by undo).
//  6. Assert rst_n low mid-APPLY -> upd_en=0 and req_ready=1 immediately; a following undo gives err.

Source files
------------

// File: rtl/move_commit_sequencer_pkg.sv
// Shared codes and the move record layout for the move commit sequencer and its history stack.
package move_commit_sequencer_pkg;

   localparam int RECW = 31;

   localparam logic [5:0] PIECE_NONE = 6'b000000;
   localparam logic [5:0] PIECE_P    = 6'b000001;
   localparam logic [5:0] PIECE_R    = 6'b000010;
   localparam logic [5:0] PIECE_N    = 6'b000100;
   localparam logic [5:0] PIECE_B    = 6'b001000;
   localparam logic [5:0] PIECE_Q    = 6'b010000;
   localparam logic [5:0] PIECE_K    = 6'b100000;

   localparam logic [1:0] CASTLE_NONE  = 2'b00;
   localparam logic [1:0] CASTLE_QUEEN = 2'b01;
   localparam logic [1:0] CASTLE_KING  = 2'b10;

   localparam logic [4:0] EP_NONE = 5'b00001;
   localparam logic [4:0] EP_UL   = 5'b00010;
   localparam logic [4:0] EP_UR   = 5'b00100;
   localparam logic [4:0] EP_DL   = 5'b01000;
   localparam logic [4:0] EP_DR   = 5'b10000;

   localparam logic WHITE = 1'b1;
   localparam logic BLACK = 1'b0;

   // Bit offsets of each field inside the packed record (MSB first: from .. enpassant)
   localparam int OFS_FROM      = 25;
   localparam int OFS_TO        = 19;
   localparam int OFS_MOVING    = 13;
   localparam int OFS_CAPTURED  = 7;
   localparam int OFS_CASTLING  = 5;
   localparam int OFS_ENPASSANT = 0;

   typedef struct packed {
      logic [5:0] from;
      logic [5:0] to;
      logic [5:0] moving;
      logic [5:0] captured;
      logic [1:0] castling;
      logic [4:0] enpassant;
   } moveRec_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INIT  = 2'd1,
      ST_APPLY = 2'd2,
      ST_DONE  = 2'd3
   } seqState_e;

   localparam moveRec_t REC_RESET = '{
      from:      6'd0,
      to:        6'd0,
      moving:    PIECE_NONE,
      captured:  PIECE_NONE,
      castling:  CASTLE_NONE,
      enpassant: EP_NONE
   };

endpackage

// File: rtl/move_history_lifo.sv
// LIFO of played move records; the top entry is read combinationally so an undo can load it on the pop edge.
module move_history_lifo #(
   parameter int DEPTH = 64,
   parameter int W     = 31
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wrData,
   output logic [W-1:0]           topData,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [CW-1:0] sp_r;
   logic [AW-1:0] topIdx_s;

   assign full     = (sp_r == CW'(DEPTH));
   assign empty    = (sp_r == CW'(0));
   assign count    = sp_r;
   assign topIdx_s = sp_r[AW-1:0] - AW'(1);
   assign topData  = mem_r[topIdx_s];

   // Stack pointer: clear wins, push and pop are ignored when they would overflow/underflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_r <= CW'(0);
      end else if (clear) begin
         sp_r <= CW'(0);
      end else if (push && !full) begin
         sp_r <= sp_r + CW'(1);
      end else if (pop && !empty) begin
         sp_r <= sp_r - CW'(1);
      end else begin
         sp_r <= sp_r;
      end
   end

   // Record storage, written at the current stack pointer on a legal push
   always_ff @(posedge clk) begin
      if (push && !full && !clear) begin
         mem_r[sp_r[AW-1:0]] <= wrData;
      end
   end

endmodule

// File: rtl/move_commit_sequencer.sv
// Sole master of the board updater: accepts apply/undo/new-game requests, keeps the move history
// and holds the updater fields stable with upd_en=1 for SETTLE cycles before pulsing done.
module move_commit_sequencer
   import move_commit_sequencer_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int SETTLE = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   new_game,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_undo,
   input  logic [5:0]             req_from,
   input  logic [5:0]             req_to,
   input  logic [5:0]             req_moving,
   input  logic [5:0]             req_captured,
   input  logic [1:0]             req_castling,
   input  logic [4:0]             req_enpassant,
   output logic                   done,
   output logic                   err,
   output logic [$clog2(DEPTH):0] hist_count,
   output logic                   color_type,
   output logic                   upd_en,
   output logic                   upd_init,
   output logic                   upd_undo,
   output logic [63:0]            upd_initialPosition,
   output logic [63:0]            upd_movedPosition,
   output logic [5:0]             upd_movingPiece,
   output logic [5:0]             upd_capturedPiece,
   output logic [1:0]             upd_castling,
   output logic [4:0]             upd_enpassant
);

   localparam int SW = $clog2(SETTLE) + 1;

   function automatic logic [63:0] sqToOneHot(input logic [5:0] idx);
      return 64'd1 << idx;
   endfunction

   seqState_e     state_r, stateNext_s;
   logic [SW-1:0] settleCnt_r;

   moveRec_t   reqRec_s, topRec_s, loadRec_s, updRec_r;
   logic [RECW-1:0] topVec_s;
   logic       accept_s, pushOk_s, popOk_s, reject_s, clear_s, loadEn_s;
   logic       full_s, empty_s;
   logic       updEnNext_s, updInitNext_s, doneNext_s;
   logic       updEn_r, updInit_r, updUndo_r, done_r, err_r, color_r;
   logic [63:0] initPos_r, movedPos_r;

   assign reqRec_s  = {req_from, req_to, req_moving, req_captured, req_castling, req_enpassant};
   assign topRec_s  = topVec_s;
   assign req_ready = (state_r == ST_IDLE) && !new_game;
   assign accept_s  = req_valid && req_ready;
   assign pushOk_s  = accept_s && !req_undo && !full_s;
   assign popOk_s   = accept_s && req_undo && !empty_s;
   assign reject_s  = accept_s && (req_undo ? empty_s : full_s);
   assign clear_s   = (state_r == ST_IDLE) && new_game;
   assign loadEn_s  = pushOk_s || popOk_s;

   move_history_lifo #(.DEPTH(DEPTH), .W(RECW)) uHistory (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear_s),
      .push    (pushOk_s),
      .pop     (popOk_s),
      .wrData  (reqRec_s),
      .topData (topVec_s),
      .full    (full_s),
      .empty   (empty_s),
      .count   (hist_count)
   );

   // State register and settle-window counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         settleCnt_r <= SW'(0);
      end else begin
         state_r <= stateNext_s;
         if ((state_r == ST_INIT) || (state_r == ST_APPLY)) begin
            settleCnt_r <= settleCnt_r + SW'(1);
         end else begin
            settleCnt_r <= SW'(0);
         end
      end
   end

   // Next-state logic; new_game only takes effect from IDLE
   always_comb begin
      stateNext_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (new_game) begin
               stateNext_s = ST_INIT;
            end else if (loadEn_s) begin
               stateNext_s = ST_APPLY;
            end else begin
               stateNext_s = ST_IDLE;
            end
         end
         ST_INIT, ST_APPLY: begin
            if (settleCnt_r == SW'(SETTLE - 1)) begin
               stateNext_s = ST_DONE;
            end else begin
               stateNext_s = state_r;
            end
         end
         ST_DONE: stateNext_s = ST_IDLE;
         default: stateNext_s = ST_IDLE;
      endcase
   end

   // Output decode, evaluated one cycle ahead so every output leaves a flop
   always_comb begin
      updEnNext_s   = (stateNext_s == ST_INIT) || (stateNext_s == ST_APPLY);
      updInitNext_s = (stateNext_s == ST_INIT);
      doneNext_s    = (stateNext_s == ST_DONE);
      if (pushOk_s) begin
         loadRec_s = reqRec_s;
      end else begin
         loadRec_s = topRec_s;
      end
   end

   // Output registers; updater fields only change on an accepted apply/undo
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         updEn_r    <= 1'b0;
         updInit_r  <= 1'b0;
         updUndo_r  <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         color_r    <= WHITE;
         updRec_r   <= REC_RESET;
         initPos_r  <= 64'd0;
         movedPos_r <= 64'd0;
      end else begin
         updEn_r   <= updEnNext_s;
         updInit_r <= updInitNext_s;
         done_r    <= doneNext_s;
         err_r     <= reject_s;
         if (clear_s) begin
            color_r <= WHITE;
         end else if ((state_r == ST_APPLY) && (stateNext_s == ST_DONE)) begin
            color_r <= ~color_r;
         end else begin
            color_r <= color_r;
         end
         if (loadEn_s) begin
            updUndo_r  <= popOk_s;
            updRec_r   <= loadRec_s;
            initPos_r  <= sqToOneHot(loadRec_s.from);
            movedPos_r <= sqToOneHot(loadRec_s.to);
         end else begin
            updUndo_r  <= updUndo_r;
            updRec_r   <= updRec_r;
            initPos_r  <= initPos_r;
            movedPos_r <= movedPos_r;
         end
      end
   end

   assign done                = done_r;
   assign err                 = err_r;
   assign color_type          = color_r;
   assign upd_en              = updEn_r;
   assign upd_init            = updInit_r;
   assign upd_undo            = updUndo_r;
   assign upd_initialPosition = initPos_r;
   assign upd_movedPosition   = movedPos_r;
   assign upd_movingPiece     = updRec_r.moving;
   assign upd_capturedPiece   = updRec_r.captured;
   assign upd_castling        = updRec_r.castling;
   assign upd_enpassant       = updRec_r.enpassant;

endmodule
